// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin write arbiter in front of the shared d_flip_flop register.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 4;

endpackage

// File: rtl/d_flip_flop.sv
// Shared WIDTH-bit enable-gated register that the arbiter writes through.
module d_flip_flop #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (enable) begin
            q <= data;
        end
    end

endmodule

// File: rtl/dff_write_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: searches upward from rr_ptr+1 (mod NUM_REQ) for the first set request.
module rr_priority_picker
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0]   winner_idx,
    output logic               any_req
);

    localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the nearest candidate after rr_ptr wins.
    always_comb begin
        winner_idx    = '0;
        winner_onehot = '0;
        any_req       = |req;
        sum           = '0;
        cand          = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[IDX_W-1:0];
            if (req[cand]) begin
                winner_idx = cand;
            end
        end
        if (any_req) begin
            winner_onehot[winner_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dff_write_arbiter.sv
// Round-robin arbiter sharing one enable-gated register among NUM_REQ writers; each grant runs
// select, write, verify/acknowledge and the read-back is checked against the latched data.
module dff_write_arbiter
    import dff_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     ff_enable,
    output logic [WIDTH-1:0]         ff_data,
    input  logic [WIDTH-1:0]         ff_q,
    output logic                     busy,
    output logic                     verify_err
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   wdata_q, wdata_d;
    logic               verify_err_q, verify_err_d;

    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               win_any;
    logic [WIDTH-1:0]   data_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
    end

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req           (req),
        .rr_ptr        (rr_ptr_q),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx),
        .any_req       (win_any)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        idx_d        = idx_q;
        rr_ptr_d     = rr_ptr_q;
        wdata_d      = wdata_q;
        verify_err_d = verify_err_q;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    grant_d = win_onehot;
                    idx_d   = win_idx;
                    wdata_d = data_arr[win_idx];
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = DONE;
            end
            DONE: begin
                // The register captured wdata on the WRITE edge, so q must match by now.
                if (ff_q != wdata_q) begin
                    verify_err_d = 1'b1;
                end
                rr_ptr_d = idx_q;
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            idx_q        <= '0;
            rr_ptr_q     <= IDX_W'(NUM_REQ-1);
            wdata_q      <= '0;
            verify_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            idx_q        <= idx_d;
            rr_ptr_q     <= rr_ptr_d;
            wdata_q      <= wdata_d;
            verify_err_q <= verify_err_d;
        end
    end

    assign grant      = grant_q;
    assign ack        = (state_q == DONE) ? grant_q : '0;
    assign ff_enable  = (state_q == WRITE);
    assign ff_data    = wdata_q;
    assign busy       = (state_q != IDLE);
    assign verify_err = verify_err_q;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// Directed bench for dff_write_arbiter driving a real d_flip_flop, with a scoreboard of expected writes.
module tb_dff_write_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           ff_rst;
    logic           q_zero;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [N-1:0]   ack;
    logic           ff_enable;
    logic [W-1:0]   ff_data;
    logic [W-1:0]   ff_q;
    logic [W-1:0]   dff_q;
    logic           busy;
    logic           verify_err;

    always #5 clk = ~clk;

    // q_zero models a broken read-back path for the verify-error case.
    assign ff_q = q_zero ? '0 : dff_q;

    dff_write_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .ack        (ack),
        .ff_enable  (ff_enable),
        .ff_data    (ff_data),
        .ff_q       (ff_q),
        .busy       (busy),
        .verify_err (verify_err)
    );

    d_flip_flop #(.WIDTH(W)) u_ff (
        .clk    (clk),
        .reset  (ff_rst),
        .enable (ff_enable),
        .data   (ff_data),
        .q      (dff_q)
    );

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   ref_ptr  = N - 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int pick(input logic [N-1:0] rv, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (rv[(ptr + k) % N]) return (ptr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // mode: 0 normal, 1 change data and drop req in WRITE, 2 bad read-back, 3 reset in DONE
    task automatic do_write(input logic [N-1:0] rv, input logic [N*W-1:0] dv,
                            input int mode, input logic exp_err);
        exp_t e;
        exp_t got;
        req      = rv;
        req_data = dv;
        e.idx    = pick(rv, ref_ptr);
        e.data   = dv[e.idx*W +: W];
        sb.push_back(e);
        $display("txn req=%b winner=%0d data=%h mode=%0d", rv, e.idx, e.data, mode);
        @(negedge clk);
        chk("grant_after_E0", 32'(grant), 32'(onehot(e.idx)));
        chk("enable_after_E0", 32'(ff_enable), 32'd1);
        chk("busy_after_E0", 32'(busy), 32'd1);
        chk("ffdata_after_E0", 32'(ff_data), 32'(e.data));
        chk("ack_after_E0", 32'(ack), 32'd0);
        if (mode == 1) begin
            req_data = ~dv;
            req      = '0;
        end
        @(negedge clk);
        got = sb.pop_front();
        chk("ack_after_E1", 32'(ack), 32'(onehot(got.idx)));
        chk("enable_after_E1", 32'(ff_enable), 32'd0);
        chk("ffq_after_E1", 32'(ff_q), 32'(got.data));
        if (mode == 2) q_zero = 1'b1;
        if (mode == 3) begin
            reset = 1'b1;
            @(negedge clk);
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_grant", 32'(grant), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ffdata", 32'(ff_data), 32'd0);
            chk("rst_reg_kept", 32'(ff_q), 32'(got.data));
            reset   = 1'b0;
            req     = '0;
            ref_ptr = N - 1;
        end else begin
            @(negedge clk);
            chk("ack_after_E2", 32'(ack), 32'd0);
            chk("grant_after_E2", 32'(grant), 32'd0);
            chk("busy_after_E2", 32'(busy), 32'd0);
            chk("verr_after_E2", 32'(verify_err), 32'(exp_err));
            q_zero  = 1'b0;
            ref_ptr = got.idx;
        end
    endtask

    initial begin
        reset    = 1'b1;
        ff_rst   = 1'b1;
        q_zero   = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        ff_rst = 1'b0;

        // Idle after reset: everything quiet for 10 cycles.
        for (int c = 0; c < 10; c++) begin
            chk("idle_outputs", 32'({grant, ack, ff_enable, ff_data, busy, verify_err}), 32'd0);
            @(negedge clk);
        end

        // Fairness: all requesting, then requester 0 withdraws.
        for (int r = 0; r < 4; r++) do_write(4'b1111, 16'h963C, 0, 1'b0);
        for (int r = 0; r < 4; r++) do_write(4'b1110, 16'h963C, 0, 1'b0);

        // Single request from requester 2.
        do_write(4'b0100, 16'h0A00, 0, 1'b0);
        req = '0;
        @(negedge clk);

        // Data changed and req dropped during WRITE.
        do_write(4'b0001, 16'h0003, 1, 1'b0);

        // Reset while in DONE; pointer must return to NUM_REQ-1.
        do_write(4'b0010, 16'h00E0, 3, 1'b0);
        chk("rst_verr", 32'(verify_err), 32'd0);
        do_write(4'b1001, 16'h7005, 0, 1'b0);
        req = '0;
        @(negedge clk);

        // Broken read-back sets the sticky error.
        do_write(4'b0100, 16'h0500, 2, 1'b1);
        do_write(4'b1000, 16'hB000, 0, 1'b1);
        req = '0;
        repeat (3) @(negedge clk);
        chk("verr_sticky", 32'(verify_err), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("verr_cleared", 32'(verify_err), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
